// File: rtl/truth_table_sweeper_if.sv
// Handshake bundle between a truth_table_sweeper and the logic that wraps it.
// master drives control and the DUT response; slave is the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int T = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [T-1:0]    exp_table;
  logic            f_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic [T-1:0]    table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic            pass;

  modport master (
    output start, abort, exp_table, f_in,
    input  vec_out, busy, done, table_out, mismatch_cnt, pass
  );

  modport slave (
    input  start, abort, exp_table, f_in,
    output vec_out, busy, done, table_out, mismatch_cnt, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a small combinational DUT, DWELL cycles each, and captures its truth table.
// done pulses the cycle after edge E0+T*DWELL+1; no backpressure, start is ignored unless idle.
module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int T  = 1 << N_IN;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = N_IN'(T - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dwell_cnt;
  logic [T-1:0]    exp_latched;
  logic            start_ok;
  logic            vec_last;
  logic [N_IN:0]   mism_now;

  function automatic logic [N_IN:0] popcount(input logic [T-1:0] x);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < T; i++) c = c + {{N_IN{1'b0}}, x[i]};
    return c;
  endfunction

  // The done-pulse cycle still belongs to the finished sweep, so start is not honoured there.
  assign start_ok = (state == IDLE) && bus.start && !bus.abort && !bus.done;
  assign vec_last = (dwell_cnt == DWELL_LAST);
  assign mism_now = popcount(bus.table_out ^ exp_latched);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = DRIVE;
      DRIVE: begin
        if (bus.abort)                              state_nxt = IDLE;
        else if (vec_last && bus.vec_out == VEC_LAST) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vec_out      <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.table_out    <= '0;
      bus.mismatch_cnt <= '0;
      bus.pass         <= 1'b0;
      dwell_cnt        <= '0;
      exp_latched      <= '0;
    end else begin
      bus.done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start_ok) begin
            bus.vec_out   <= '0;
            bus.table_out <= '0;
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            dwell_cnt     <= '0;
            exp_latched   <= bus.exp_table;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
          end else if (!vec_last) begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end else begin
            bus.table_out[bus.vec_out] <= bus.f_in;
            dwell_cnt                  <= '0;
            if (bus.vec_out == VEC_LAST) bus.busy    <= 1'b0;
            else                         bus.vec_out <= bus.vec_out + N_IN'(1);
          end
        end
        FINISH: begin
          bus.mismatch_cnt <= mism_now;
          bus.pass         <= (mism_now == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] fn0;
  logic [3:0] fn1;
  int         last_mm0;
  logic       last_pass0;

  truth_table_sweeper_if #(.N_IN(3)) if0 ();
  truth_table_sweeper_if #(.N_IN(2)) if1 ();

  // Behavioural DUT: a lookup table indexed by the applied vector.
  assign if0.f_in = fn0[if0.vec_out];
  assign if1.f_in = fn1[if1.vec_out];

  truth_table_sweeper #(.N_IN(3), .DWELL(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_sweeper #(.N_IN(2), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on the 3-input/DWELL=4 instance; poke re-asserts start mid-sweep and on the done cycle.
  task automatic sweep0(input string tag, input logic [7:0] fn, input logic [7:0] ex, input bit poke);
    int   done_cnt, done_at, mm_at_done, exp_vec;
    logic pass_at_done;
    bit   seq_ok;
    fn0 = fn;
    if0.exp_table = ex;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if0.exp_table = ~ex;
    done_cnt = 0; done_at = -1; seq_ok = 1'b1; mm_at_done = -1; pass_at_done = 1'bx;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      exp_vec = (n < 32) ? n / 4 : 7;
      if (if0.vec_out !== 3'(exp_vec)) seq_ok = 1'b0;
      if (if0.busy !== (n < 32)) seq_ok = 1'b0;
      if (if0.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 33) begin
        mm_at_done   = int'(if0.mismatch_cnt);
        pass_at_done = if0.pass;
      end
      if (poke) if0.start = (n == 10 || n == 33);
    end
    if0.start = 1'b0;
    last_mm0   = $countones(fn ^ ex);
    last_pass0 = (last_mm0 == 0);
    chk({tag, "_seq"},   64'(seq_ok), 64'd1);
    chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    chk({tag, "_tdone"}, 64'(done_at), 64'd33);
    chk({tag, "_table"}, 64'(if0.table_out), 64'(fn));
    chk({tag, "_mm"},    64'(mm_at_done), 64'(last_mm0));
    chk({tag, "_pass"},  64'(pass_at_done), 64'(last_pass0));
    chk({tag, "_hold"},  64'({if0.mismatch_cnt, if0.pass}), 64'({4'(last_mm0), last_pass0}));
  endtask

  task automatic sweep1(input string tag, input logic [3:0] fn, input logic [3:0] ex);
    int  done_cnt, done_at, exp_vec, mm;
    bit  seq_ok;
    fn1 = fn;
    if1.exp_table = ex;
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    if1.exp_table = ~ex;
    done_cnt = 0; done_at = -1; seq_ok = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      exp_vec = (n < 4) ? n : 3;
      if (if1.vec_out !== 2'(exp_vec)) seq_ok = 1'b0;
      if (if1.busy !== (n < 4)) seq_ok = 1'b0;
      if (if1.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    mm = $countones(fn ^ ex);
    chk({tag, "_seq"},   64'(seq_ok), 64'd1);
    chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    chk({tag, "_tdone"}, 64'(done_at), 64'd5);
    chk({tag, "_table"}, 64'(if1.table_out), 64'(fn));
    chk({tag, "_res"},   64'({if1.mismatch_cnt, if1.pass}), 64'({3'(mm), mm == 0}));
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    fn0 = '0; fn1 = '0;
    if0.start = 1'b0; if0.abort = 1'b0; if0.exp_table = '0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.exp_table = '0;
    last_mm0 = 0; last_pass0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset0", 64'({if0.vec_out, if0.busy, if0.done, if0.table_out, if0.mismatch_cnt, if0.pass}), 64'd0);
    chk("reset1", 64'({if1.vec_out, if1.busy, if1.done, if1.table_out, if1.mismatch_cnt, if1.pass}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    sweep0("buf", 8'hAA, 8'hAA, 1'b0);
    sweep0("and3", 8'h80, 8'h81, 1'b0);

    // Abort at vector 3 with f tied high.
    fn0 = 8'hFF;
    if0.exp_table = 8'h00;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_pre_vec", 64'(if0.vec_out), 64'd3);
    if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(if0.busy), 64'd0);
    chk("abort_vec", 64'(if0.vec_out), 64'd3);
    chk("abort_table", 64'(if0.table_out), 64'h07);
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if0.done === 1'b1) done_cnt++;
    end
    chk("abort_ndone", 64'(done_cnt), 64'd0);
    chk("abort_res", 64'({if0.mismatch_cnt, if0.pass}), 64'({4'(last_mm0), 1'b0}));

    // start and abort together in IDLE: abort wins.
    if0.start = 1'b1; if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0; if0.abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", 64'(if0.busy), 64'd0);

    sweep0("poke", 8'h3C, 8'h5A, 1'b1);

    // Asynchronous reset between edges mid-sweep.
    fn0 = 8'h96;
    if0.exp_table = 8'h0F;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_outs", 64'({if0.vec_out, if0.busy, if0.done, if0.table_out, if0.mismatch_cnt, if0.pass}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep0("after_rst", 8'h96, 8'h96, 1'b0);

    for (int i = 0; i < 3; i++) begin
      sweep0($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'b0);
    end

    sweep1("xor", 4'h6, 4'h6);
    for (int i = 0; i < 2; i++) begin
      sweep1($sformatf("rnd1_%0d", i), 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
